// File: rtl/screen_pkg.sv
// Shared constants, state encoding and address helper for the Hack screen scanout.
package screen_pkg;

    localparam int SCREEN_BASE = 16384;
    localparam int ROW_WORDS   = 32;
    localparam int ROWS        = 256;
    localparam int ADDR_W      = 13;

    localparam int ROW_W  = $clog2(ROWS + 1);
    localparam int WCNT_W = $clog2(ROW_WORDS + 1);

    localparam logic [ROW_W-1:0]  ROW_LIMIT  = ROW_W'(ROWS);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(ROW_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } scan_state_e;

    // Only called with row < ROWS and col < ROW_WORDS, so the result never wraps.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_W-1:0]  row,
                                                    input logic [WCNT_W-1:0] col);
        return ADDR_W'(int'(row) * ROW_WORDS + int'(col));
    endfunction

endpackage

// File: rtl/screen_shifter.sv
// 16-bit load/shift register with bit count; bit 0 is the next pixel out.
module screen_shifter
    import screen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [15:0] load_data_i,
    input  logic        shift_i,
    output logic        bit0_o,
    output logic        empty_o,
    output logic        last_o
);

    logic [15:0] data_q;
    logic [4:0]  count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            data_q  <= '0;
            count_q <= '0;
        end else if (load_i) begin
            data_q  <= load_data_i;
            count_q <= 5'd16;
        end else if (shift_i && count_q != 5'd0) begin
            data_q  <= data_q >> 1;
            count_q <= count_q - 5'd1;
        end
    end

    assign bit0_o  = data_q[0];
    assign empty_o = (count_q == 5'd0);
    assign last_o  = (count_q == 5'd1);

endmodule

// File: rtl/screen_scanout.sv
// Screen RAM reader: fetches words by req/ack and serialises one pixel per consumed pix_ce.
// Build option: define SCREEN_INVERT_EN to output inverted pixels (blank pixels then read 1).
//   state   | meaning
//   IDLE    | no read outstanding
//   REQ     | read outstanding, data will be kept
//   DISCARD | read outstanding across a line/frame start, data will be dropped
module screen_scanout
    import screen_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_ce,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              active,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [15:0]       rd_data,
    output logic              pix_out,
    output logic              pix_valid,
    output logic              underrun
);

`ifdef SCREEN_INVERT_EN
    localparam logic PIX_INV = 1'b1;
`else
    localparam logic PIX_INV = 1'b0;
`endif

    scan_state_e       state_q;
    logic [ROW_W-1:0]  row_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              first_line_q;
    logic              rd_req_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [15:0]       holder_q;
    logic              hold_full_q;
    logic              pix_out_q;
    logic              pix_valid_q;
    logic              underrun_q;

    logic frame_ev, line_ev, consume, row_valid;
    logic sh_bit, sh_empty, sh_last, sh_load, sh_shift;
    logic [15:0] sh_load_data;
    logic take_ack, ack_to_shifter, ack_to_holder, hold_to_shifter;

    // frame_start also flushes the line, so it counts as a line event here.
    assign frame_ev  = pix_ce & frame_start;
    assign line_ev   = pix_ce & (line_start | frame_start);
    assign consume   = pix_ce & active;
    assign row_valid = (row_q < ROW_LIMIT);

    assign take_ack        = (state_q == ST_REQ) & rd_ack & ~line_ev;
    assign ack_to_shifter  = take_ack & sh_empty;
    assign ack_to_holder   = take_ack & ~sh_empty;
    assign sh_shift        = consume & ~sh_empty;
    assign hold_to_shifter = hold_full_q & (sh_empty | (sh_shift & sh_last));
    assign sh_load         = ack_to_shifter | hold_to_shifter;
    assign sh_load_data    = hold_to_shifter ? holder_q : rd_data;

    screen_shifter u_shifter (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (line_ev),
        .load_i      (sh_load),
        .load_data_i (sh_load_data),
        .shift_i     (sh_shift),
        .bit0_o      (sh_bit),
        .empty_o     (sh_empty),
        .last_o      (sh_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            wcnt_q       <= '0;
            first_line_q <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            if (frame_ev) begin
                row_q        <= '0;
                first_line_q <= ~line_start;
            end else if (line_ev) begin
                first_line_q <= 1'b0;
                if (first_line_q)
                    row_q <= '0;
                else if (row_valid)
                    row_q <= row_q + ROW_W'(1);
            end

            if (line_ev)
                wcnt_q <= '0;
            else if (take_ack && wcnt_q < WCNT_LIMIT)
                wcnt_q <= wcnt_q + WCNT_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (!line_ev && !hold_full_q && wcnt_q < WCNT_LIMIT && row_valid) begin
                        state_q   <= ST_REQ;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= word_addr(row_q, wcnt_q);
                    end
                end
                ST_REQ: begin
                    if (rd_ack) begin
                        state_q  <= ST_IDLE;
                        rd_req_q <= 1'b0;
                    end else if (line_ev) begin
                        state_q <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (rd_ack) begin
                        state_q  <= ST_IDLE;
                        rd_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rd_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            holder_q    <= '0;
            hold_full_q <= 1'b0;
        end else if (line_ev) begin
            hold_full_q <= 1'b0;
        end else if (ack_to_holder) begin
            holder_q    <= rd_data;
            hold_full_q <= 1'b1;
        end else if (hold_to_shifter) begin
            hold_full_q <= 1'b0;
        end
    end

    // Blank rows are quiet; a starved visible row flags underrun.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_out_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            pix_valid_q <= consume;
            if (consume) begin
                if (!row_valid || sh_empty)
                    pix_out_q <= PIX_INV;
                else
                    pix_out_q <= sh_bit ^ PIX_INV;
            end
            if (frame_ev)
                underrun_q <= 1'b0;
            else if (consume && row_valid && sh_empty)
                underrun_q <= 1'b1;
        end
    end

    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench for screen_scanout with a behavioural screen RAM responder.
module tb_screen_scanout;
    import screen_pkg::*;

`ifdef SCREEN_INVERT_EN
    localparam logic BLANK = 1'b1;
`else
    localparam logic BLANK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, pix_ce, frame_start, line_start, active;
    logic              rd_req, rd_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic              pix_out, pix_valid, underrun;

    logic        resp_en;
    logic        ack_auto = 1'b0;
    logic        ack_man;
    logic [15:0] data_auto = 16'h0;
    logic [15:0] data_man;
    int          lat;
    int          rcnt = 0;
    logic [15:0] mem [0:8191];

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] addr_q [$];
    logic              req_prev = 1'b0;

    assign rd_ack  = resp_en ? ack_auto : ack_man;
    assign rd_data = resp_en ? data_auto : data_man;

    screen_scanout dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .frame_start (frame_start),
        .line_start  (line_start),
        .active      (active),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .pix_out     (pix_out),
        .pix_valid   (pix_valid),
        .underrun    (underrun)
    );

    // RAM responder: acks lat clocks after it first sees rd_req.
    always @(posedge clk) begin
        ack_auto <= 1'b0;
        if (!resp_en || rd_req !== 1'b1) begin
            rcnt <= 0;
        end else if (!ack_auto) begin
            if (rcnt >= lat - 1) begin
                ack_auto  <= 1'b1;
                data_auto <= mem[rd_addr];
                rcnt      <= 0;
            end else begin
                rcnt <= rcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rd_req === 1'b1 && !req_prev)
            addr_q.push_back(rd_addr);
        req_prev = (rd_req === 1'b1);
    end

    task automatic clk_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One pix_ce pulse followed by gap idle clocks; returns pixel seen after the pulse.
    task automatic pix_tick(input logic fs, input logic ls, input logic act,
                            input int gap, output logic p, output logic v);
        pix_ce = 1'b1; frame_start = fs; line_start = ls; active = act;
        @(posedge clk);
        #1;
        p = pix_out;
        v = pix_valid;
        pix_ce = 1'b0; frame_start = 1'b0; line_start = 1'b0; active = 1'b0;
        clk_wait(gap);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pix_ce = 1'b0; frame_start = 1'b0; line_start = 1'b0;
        active = 1'b0; ack_man = 1'b0; data_man = 16'h0; resp_en = 1'b1; lat = 1;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
        clk_wait(3);
        checks++;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
        checks++;
        if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++;
        if (pix_out !== 1'b0) begin errors++; $display("FAIL reset_pix_out got=%b exp=0", pix_out); end
        checks++;
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        reset_n = 1'b1;
        clk_wait(10);
    endtask

    task automatic test_first_word();
        logic p, v;
        logic [15:0] got;
        mem[0] = 16'h0005;
        mem[1] = 16'h0000;
        pix_tick(1'b1, 1'b0, 1'b0, 3, p, v);
        pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        addr_q.delete();
        clk_wait(3);
        pix_tick(1'b0, 1'b0, 1'b0, 3, p, v);
        for (int i = 0; i < 16; i++) begin
            pix_tick(1'b0, 1'b0, 1'b1, 0, p, v);
            got[i] = p;
            if (i == 0) begin
                checks++;
                if (v !== 1'b1) begin errors++; $display("FAIL first_pix_valid got=%b exp=1", v); end
                clk_wait(1);
                checks++;
                if (pix_valid !== 1'b0) begin errors++; $display("FAIL pix_valid_width got=%b exp=0", pix_valid); end
                clk_wait(2);
            end else begin
                clk_wait(3);
            end
        end
        checks++;
        if (got !== (16'h0005 ^ {16{BLANK}}))
            begin errors++; $display("FAIL word0_pixels got=%h exp=%h", got, 16'h0005 ^ {16{BLANK}}); end
        checks++;
        if (addr_q.size() < 2 || addr_q[0] !== 13'd0 || addr_q[1] !== 13'd1) begin
            errors++;
            $display("FAIL word0_addrs n=%0d got0=%0d got1=%0d exp=0,1", addr_q.size(),
                     addr_q.size() > 0 ? addr_q[0] : '1, addr_q.size() > 1 ? addr_q[1] : '1);
        end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL word0_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_row_end();
        logic p, v;
        logic [15:0] tail;
        mem[127] = 16'h8000;
        pix_tick(1'b1, 1'b0, 1'b0, 3, p, v);
        for (int r = 0; r < 3; r++) pix_tick(1'b0, 1'b1, 1'b0, 3, p, v);
        pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        addr_q.delete();
        clk_wait(3);
        pix_tick(1'b0, 1'b0, 1'b0, 3, p, v);
        for (int i = 0; i < 512; i++) begin
            pix_tick(1'b0, 1'b0, 1'b1, 3, p, v);
            if (i >= 496) tail[i-496] = p;
        end
        checks++;
        if (tail !== (BLANK ? 16'h7FFF : 16'h8000))
            begin errors++; $display("FAIL row3_tail got=%h exp=%h", tail, BLANK ? 16'h7FFF : 16'h8000); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL row3_underrun got=%b exp=0", underrun); end
        checks++;
        if (addr_q.size() != 32 || addr_q[0] !== 13'd96 || addr_q[31] !== 13'h007F) begin
            errors++;
            $display("FAIL row3_addrs n=%0d first=%0d last=%0d exp=32,96,127", addr_q.size(),
                     addr_q.size() > 0 ? addr_q[0] : '1, addr_q.size() > 0 ? addr_q[addr_q.size()-1] : '1);
        end
        pix_tick(1'b0, 1'b0, 1'b1, 3, p, v);
        checks++;
        if (p !== BLANK) begin errors++; $display("FAIL extra_pix got=%b exp=%b", p, BLANK); end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL extra_underrun got=%b exp=1", underrun); end
    endtask

    task automatic test_underrun();
        logic p, v;
        logic [3:0] got;
        lat = 20;
        pix_tick(1'b1, 1'b0, 1'b0, 0, p, v);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL fs_clears_underrun got=%b exp=0", underrun); end
        pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        for (int i = 0; i < 4; i++) begin
            pix_tick(1'b0, 1'b0, 1'b1, 0, p, v);
            got[i] = p;
        end
        checks++;
        if (got !== {4{BLANK}}) begin errors++; $display("FAIL starved_pix got=%b exp=%b", got, {4{BLANK}}); end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL starved_underrun got=%b exp=1", underrun); end
        pix_tick(1'b1, 1'b0, 1'b0, 0, p, v);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
        lat = 1;
        clk_wait(50);
    endtask

    task automatic test_discard();
        logic p, v;
        int n;
        mem[32] = 16'h0001;
        mem[33] = 16'h0000;
        resp_en = 1'b1;
        pix_tick(1'b1, 1'b0, 1'b0, 3, p, v);
        resp_en = 1'b0;
        pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        n = 0;
        while (rd_req !== 1'b1 && n < 20) begin clk_wait(1); n++; end
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 13'd0)
            begin errors++; $display("FAIL disc_first_req req=%b addr=%0d exp=1,0", rd_req, rd_addr); end
        pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        checks++;
        if (rd_req !== 1'b1) begin errors++; $display("FAIL disc_req_held got=%b exp=1", rd_req); end
        ack_man = 1'b1;
        data_man = 16'hFFFF;
        clk_wait(1);
        ack_man = 1'b0;
        n = 0;
        while (rd_req !== 1'b1 && n < 20) begin clk_wait(1); n++; end
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 13'd32)
            begin errors++; $display("FAIL disc_next_req req=%b addr=%0d exp=1,32", rd_req, rd_addr); end
        resp_en = 1'b1;
        clk_wait(6);
        pix_tick(1'b0, 1'b0, 1'b1, 3, p, v);
        checks++;
        if (p !== (1'b1 ^ BLANK)) begin errors++; $display("FAIL disc_pix0 got=%b exp=%b", p, 1'b1 ^ BLANK); end
        pix_tick(1'b0, 1'b0, 1'b1, 3, p, v);
        checks++;
        if (p !== BLANK) begin errors++; $display("FAIL disc_pix1 got=%b exp=%b", p, BLANK); end
    endtask

    task automatic test_row_saturate();
        logic p, v;
        logic [2:0] got;
        resp_en = 1'b1;
        lat = 1;
        pix_tick(1'b1, 1'b0, 1'b0, 0, p, v);
        for (int i = 0; i < 256; i++) pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        addr_q.delete();
        clk_wait(5);
        checks++;
        if (addr_q.size() < 1 || addr_q[0] !== 13'h1FE0)
            begin errors++; $display("FAIL row255_addr n=%0d got=%0d exp=8160", addr_q.size(),
                                     addr_q.size() > 0 ? addr_q[0] : '1); end
        pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        clk_wait(8);
        addr_q.delete();
        clk_wait(20);
        checks++;
        if (addr_q.size() != 0 || rd_req !== 1'b0)
            begin errors++; $display("FAIL row256_no_req n=%0d req=%b exp=0,0", addr_q.size(), rd_req); end
        for (int i = 0; i < 3; i++) begin
            pix_tick(1'b0, 1'b0, 1'b1, 3, p, v);
            got[i] = p;
        end
        checks++;
        if (got !== {3{BLANK}}) begin errors++; $display("FAIL row256_pix got=%b exp=%b", got, {3{BLANK}}); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL row256_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_reset_mid_req();
        logic p, v;
        logic [2:0] got;
        int n;
        mem[0] = 16'h0005;
        resp_en = 1'b1;
        pix_tick(1'b1, 1'b0, 1'b0, 3, p, v);
        pix_tick(1'b0, 1'b1, 1'b0, 3, p, v);
        resp_en = 1'b0;
        pix_tick(1'b0, 1'b1, 1'b0, 0, p, v);
        n = 0;
        while (rd_req !== 1'b1 && n < 20) begin clk_wait(1); n++; end
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 13'd32)
            begin errors++; $display("FAIL rst_pending req=%b addr=%0d exp=1,32", rd_req, rd_addr); end
        reset_n = 1'b0;
        clk_wait(1);
        checks++;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL rst_drops_req got=%b exp=0", rd_req); end
        reset_n = 1'b1;
        ack_man = 1'b1;
        data_man = 16'hFFFF;
        clk_wait(1);
        ack_man = 1'b0;
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 13'd0)
            begin errors++; $display("FAIL rst_next_req req=%b addr=%0d exp=1,0", rd_req, rd_addr); end
        resp_en = 1'b1;
        clk_wait(6);
        for (int i = 0; i < 3; i++) begin
            pix_tick(1'b0, 1'b0, 1'b1, 3, p, v);
            got[i] = p;
        end
        checks++;
        if (got !== (3'b101 ^ {3{BLANK}}))
            begin errors++; $display("FAIL rst_pixels got=%b exp=%b", got, 3'b101 ^ {3{BLANK}}); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_row_end();
        test_underrun();
        test_discard();
        test_row_saturate();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/screen_scanout.md
Name: screen_scanout

Overview:
- Reader side of the Hack screen memory map: the CPU writes pixels into screen RAM (8K x 16 words), and this block reads them back for video.
- Fetches words over a request/ack port and serialises them into one pixel per enabled video clock.
- Sits between screen RAM's second port and the MiSTer video timing generator.
- Hack pixel mapping: pixel (r,c) is bit c%16 of word r*32 + c/16, with bit 0 leftmost.

Parameters:
- ROW_WORDS, 32, words per scanline (512 px / 16).
- ROWS, 256, visible rows; rows at or beyond this are blank.
- ADDR_W, 13, screen RAM word address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- pix_ce  input  1  pixel clock enable; all video inputs are sampled only when high.
- frame_start  input  1  pulse qualified by pix_ce; row := 0.
- line_start  input  1  pulse qualified by pix_ce; next row begins.
- active  input  1  with pix_ce, consume one pixel.
- rd_req  output  1  read request, held until rd_ack.
- rd_addr  output  ADDR_W  word address, stable while rd_req is high.
- rd_ack  input  1  one-cycle pulse; rd_data is valid in that cycle; latency >=1 clk.
- rd_data  input  16  screen word.
- pix_out  output  1  pixel value.
- pix_valid  output  1  high one clk after each consumed pixel.
- underrun  output  1  sticky flag; cleared at frame_start.

Behaviour:
- Reset values: rd_req=0, rd_addr=0, pix_out=0, pix_valid=0, underrun=0. Row=0, word counter=0, shifter and holder empty, FSM=IDLE.
- Storage: 16-bit shifter with 5-bit bit count, plus a one-word holding register.
  - When the shifter's last bit is consumed and the holder is full, the holder loads into the shifter in the same clk, so there is no bubble.
- FSM states IDLE, REQ, DISCARD:
  - IDLE -> REQ when the holder is empty, word counter < ROW_WORDS and row < ROWS. In that clk: rd_addr := row*ROW_WORDS + word counter, rd_req := 1.
  - REQ, rd_ack -> IDLE. rd_req := 0, and data goes to the shifter if it is empty, otherwise to the holder. Word counter +1.
  - REQ, line_start or frame_start before rd_ack -> DISCARD.
  - DISCARD, rd_ack -> IDLE. Data is dropped and rd_req := 0.
- line_start:
  - Flush shifter and holder; word counter := 0.
  - Row := row+1, saturating at ROWS. The first line_start after frame_start selects row 0, so frame_start sets an internal "first line" flag.
- frame_start together with line_start: frame_start wins; row 0 is fetched.
- Pixel consume (pix_ce & active):
  - pix_out := shifter bit 0 and the shifter shifts right. pix_valid := 1 for exactly one clk.
  - If the shifter is empty, pix_out := 0 and underrun := 1. The counter and state are unchanged.
- Rows >= ROWS: no fetches; consumed pixels output 0 without setting underrun.
- Word counter saturates at ROW_WORDS. Extra active pixels on a line output 0 and set underrun.
- Timing requirement: the first active pixel must come no earlier than 2 pix_ce after line_start when rd latency is <=2 clk and pix_ce runs at <=1/4 of clk. Violations are reported only through underrun.
- Reset mid-request: rd_req drops the next clk. A late rd_ack arrives while in IDLE and is ignored.
- Address arithmetic: row*32 + col fits 13 bits. There is no wrap; saturation guarantees this.

Optional Feature:
- Macro: SCREEN_INVERT_EN.
- Defined: pix_out is the inverse of the stored bit, because Hack 1 = black and video 1 = white. Blank, underrun and out-of-range pixels then output 1 (white).
- Not defined: pix_out is the raw bit, and blank pixels output 0.

Decomposition:
- Package screen_pkg: SCREEN_BASE (16384, CPU view only), ROW_WORDS, ROWS, ADDR_W, and the FSM state encoding.
- One sub-module, screen_shifter: 16-bit load/shift register with bit count, plus the empty flag.

Test Plan:
- RAM word 0 = 16'h0005, latency 1. Sequence frame_start, line_start, then 16 active pixels -> pix_out 1,0,1,0,0... and rd_addr 0 then 1.
- Row 3, word 31 = 16'h8000. Pixel 511 of the 4th line = 1; rd_addr = 127 (13'h007F).
- RAM latency 20 clk with pix_ce every clk -> underrun = 1 and pix_out = 0 for starved pixels. underrun clears at the next frame_start.
- line_start while rd_req is pending, then ack data 16'hFFFF -> data discarded and a new request to the next row's word 0.
- 257 line_starts after frame_start -> no rd_req on the 257th row; pixels output 0 (1 with SCREEN_INVERT_EN).
- reset_n low for 1 clk during REQ, then a stale rd_ack -> rd_req is 0, and the following fetch uses rd_addr 0.
